// File: rtl/lzd_norm_seq.sv
// Sequential leading-zero counter / normalizer: scans an operand MSB-first one chunk per cycle.
// Optional post-scan barrel shift compiled in with `LZD_NORM_SHIFT_EN`.

module LeadZeroDet #(
  parameter int width = 8,
  parameter int speed = 0
) (
  input  logic [width-1:0] d,
  output logic [width-1:0] oh
);
  if (speed == 0) begin : g_ripple
    always_comb begin
      logic found;
      oh    = '0;
      found = 1'b0;
      for (int i = width-1; i >= 0; i--) begin
        if (d[i] && !found) begin
          oh[i] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end else begin : g_par
    // each bit is the leading one iff it is set and nothing above it is
    assign oh[width-1] = d[width-1];
    for (genvar i = 0; i < width-1; i++) begin : g_bit
      assign oh[i] = d[i] & ~(|d[width-1:i+1]);
    end
  end
endmodule

module lzd_norm_seq #(
  parameter int width = 32,
  parameter int chunk = 8,
  parameter int speed = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [width-1:0]               in_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [$clog2(width+1)-1:0]     out_count_o,
  output logic                           out_zero_o,
  output logic [width-1:0]               out_data_o
);
  localparam int nchunks = width / chunk;
  localparam int cw      = $clog2(width + 1);
  localparam int pw      = $clog2(chunk);
  localparam int iw      = (nchunks > 1) ? $clog2(nchunks) : 1;
`ifdef LZD_NORM_SHIFT_EN
  localparam int sw      = $clog2(width);
`endif

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [width-1:0] op;
  logic [iw-1:0]    idx;
  logic [cw-1:0]    cnt;
  logic             zflag;
  logic [chunk-1:0] slice, oh;
  logic [pw-1:0]    p;
  logic             slice_nz, last, accept;

  always_comb begin
    slice = '0;
    for (int j = 0; j < nchunks; j++)
      if (idx == iw'(j)) slice = op[width-1-j*chunk -: chunk];
  end

  LeadZeroDet #(.width(chunk), .speed(speed)) u_lzd (.d(slice), .oh(oh));

  always_comb begin
    p = '0;
    for (int i = 0; i < chunk; i++)
      if (oh[i]) p = p | pw'(i);
  end

  assign slice_nz    = |slice;
  assign last        = (idx == iw'(nchunks - 1));
  assign in_ready_o  = (state == IDLE) && !rst_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state == DONE);
  // result registers double as scan state; they are only meaningful while DONE
  assign out_count_o = cnt;
  assign out_zero_o  = zflag;
  assign out_data_o  = op;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = SCAN;
      SCAN: begin
        if (slice_nz) begin
`ifdef LZD_NORM_SHIFT_EN
          state_nxt = SHIFT;
`else
          state_nxt = DONE;
`endif
        end else if (last) begin
          state_nxt = DONE;
        end
      end
      SHIFT: state_nxt = DONE;
      DONE:  if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op    <= '0;
      idx   <= '0;
      cnt   <= '0;
      zflag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op    <= in_data_i;
          idx   <= '0;
          cnt   <= '0;
          zflag <= 1'b0;
        end
        SCAN: begin
          if (slice_nz) begin
            cnt <= cnt + cw'(chunk - 1) - cw'(p);
          end else if (last) begin
            cnt   <= cw'(width);
            zflag <= 1'b1;
          end else begin
            cnt <= cnt + cw'(chunk);
            idx <= idx + iw'(1);
          end
        end
`ifdef LZD_NORM_SHIFT_EN
        // cnt < width whenever the zero flag is clear, so truncation is lossless
        SHIFT: if (!zflag) op <= op << cnt[sw-1:0];
`endif
        default: ;
      endcase
    end
  end
endmodule
